// File: rtl/mm_seq_pkg.sv
// Shared types and defaults for the matrix multiply sequencer.
// Holds the FSM state encoding, default geometry, and counter/address helpers.
package mm_seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } state_e;

  localparam int unsigned DEF_N      = 3;
  localparam int unsigned DEF_DATA_W = 32;
  localparam logic [31:0] DEF_A_BASE = 32'd0;
  localparam logic [31:0] DEF_B_BASE = 32'd9;
  localparam logic [31:0] DEF_C_BASE = 32'd18;

  // A counter for N=1 still needs one bit so the vectors stay legal.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [31:0] elem_addr(input logic [31:0] base, input logic [31:0] row,
                                            input logic [31:0] col, input logic [31:0] n);
    return base + row * n + col;
  endfunction

endpackage

// File: rtl/mm_index_counter.sv
// Nested i/j/k loop counters for the sequencer.
// k steps within a dot product; an element step clears k and advances j, then i.
module mm_index_counter
  import mm_seq_pkg::*;
#(
  parameter int unsigned N  = DEF_N,
  parameter int unsigned CW = cnt_width(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          k_step,
  input  logic          elem_step,
  output logic [CW-1:0] i,
  output logic [CW-1:0] j,
  output logic [CW-1:0] k,
  output logic          k_last,
  output logic          last_elem
);

  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [CW-1:0] ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
  logic          j_last;

  assign k_last    = (k_q == LAST);
  assign j_last    = (j_q == LAST);
  assign last_elem = (i_q == LAST) && j_last;
  assign i         = i_q;
  assign j         = j_q;
  assign k         = k_q;

  // Next counter values; clear has priority over element step over k step.
  always_comb begin
    i_d = i_q;
    j_d = j_q;
    k_d = k_q;
    if (clear) begin
      i_d = ZERO;
      j_d = ZERO;
      k_d = ZERO;
    end else if (elem_step) begin
      k_d = ZERO;
      if (j_last) begin
        j_d = ZERO;
        if (i_q == LAST) begin
          i_d = ZERO;
        end else begin
          i_d = i_q + ONE;
        end
      end else begin
        j_d = j_q + ONE;
      end
    end else if (k_step) begin
      if (k_last) begin
        k_d = ZERO;
      end else begin
        k_d = k_q + ONE;
      end
    end else begin
      k_d = k_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q <= ZERO;
      j_q <= ZERO;
      k_q <= ZERO;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
      k_q <= k_d;
    end
  end

endmodule

// File: rtl/matrix_multiply_sequencer.sv
// Memory-side engine computing C = A x B over a shared word memory port.
// One read per cycle (A then B operand), one write per C element, done pulse at the end.
module matrix_multiply_sequencer
  import mm_seq_pkg::*;
#(
  parameter int unsigned N      = DEF_N,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter logic [31:0] A_BASE = DEF_A_BASE,
  parameter logic [31:0] B_BASE = DEF_B_BASE,
  parameter logic [31:0] C_BASE = DEF_C_BASE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [31:0]       mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_enable,
  output logic              mem_read_enable,
  input  logic [DATA_W-1:0] mem_read_data
);

  localparam int unsigned CW = cnt_width(N);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d, a_reg_q, a_reg_d;
  logic [CW-1:0]     idx_i, idx_j, idx_k;
  logic              k_last, last_elem, cnt_clear, k_step, elem_step;

  mm_index_counter #(.N(N), .CW(CW)) u_idx (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (cnt_clear),
    .k_step    (k_step),
    .elem_step (elem_step),
    .i         (idx_i),
    .j         (idx_j),
    .k         (idx_k),
    .k_last    (k_last),
    .last_elem (last_elem)
  );

  // Next state, loop control and multiply-accumulate.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    a_reg_d   = a_reg_q;
    cnt_clear = 1'b0;
    k_step    = 1'b0;
    elem_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RD_A;
          acc_d     = {DATA_W{1'b0}};
          cnt_clear = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RD_A: begin
        a_reg_d = mem_read_data;
        state_d = RD_B;
      end
      RD_B: begin
        // Product and sum both wrap at DATA_W bits.
        acc_d = acc_q + a_reg_q * mem_read_data;
        if (k_last) begin
          state_d = WR;
        end else begin
          k_step  = 1'b1;
          state_d = RD_A;
        end
      end
      WR: begin
        acc_d     = {DATA_W{1'b0}};
        elem_step = 1'b1;
        if (last_elem) begin
          state_d = DONE;
        end else begin
          state_d = RD_A;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Memory port and status decoded from registered state only; start never reaches them.
  always_comb begin
    busy             = 1'b0;
    done             = 1'b0;
    mem_address      = 32'd0;
    mem_write_data   = {DATA_W{1'b0}};
    mem_write_enable = 1'b0;
    mem_read_enable  = 1'b0;
    case (state_q)
      RD_A: begin
        busy            = 1'b1;
        mem_read_enable = 1'b1;
        mem_address     = elem_addr(A_BASE, 32'(idx_i), 32'(idx_k), 32'(N));
      end
      RD_B: begin
        busy            = 1'b1;
        mem_read_enable = 1'b1;
        mem_address     = elem_addr(B_BASE, 32'(idx_k), 32'(idx_j), 32'(N));
      end
      WR: begin
        busy             = 1'b1;
        mem_write_enable = 1'b1;
        mem_write_data   = acc_q;
        mem_address      = elem_addr(C_BASE, 32'(idx_i), 32'(idx_j), 32'(N));
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= {DATA_W{1'b0}};
      a_reg_q <= {DATA_W{1'b0}};
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      a_reg_q <= a_reg_d;
    end
  end

endmodule

// File: tb/tb_matrix_multiply_sequencer.sv
// Self-checking bench: random and directed matrices against a nested-loop reference product.
// Covers the default 3x3 instance and a 1x1 instance with custom base addresses.
module tb_matrix_multiply_sequencer;

  localparam int N     = 3;
  localparam int LAT   = N * N * (2 * N + 1) + 1;
  localparam int LAT1  = 1 * 1 * (2 * 1 + 1) + 1;
  localparam int CBASE = 18;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, start1, load_img, load_img1;
  logic        busy, done, we, re, busy1, done1, we1, re1;
  logic [31:0] addr, wdata, rdata, addr1, wdata1, rdata1;
  logic [31:0] mem  [0:31];
  logic [31:0] img  [0:31];
  logic [31:0] mem1 [0:3];
  logic [31:0] img1 [0:3];
  logic [31:0] exp_c [0:8];
  logic [31:0] tr_addr [0:255];
  logic        tr_re [0:255];
  logic        tr_we [0:255];
  logic        tr_busy [0:255];
  int n_checks, n_errors;
  int first_done, n_done, busy_err, excl_err;

  matrix_multiply_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .mem_address(addr), .mem_write_data(wdata), .mem_write_enable(we),
    .mem_read_enable(re), .mem_read_data(rdata)
  );

  matrix_multiply_sequencer #(.N(1), .DATA_W(32), .A_BASE(32'd0), .B_BASE(32'd1), .C_BASE(32'd2)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
    .mem_address(addr1), .mem_write_data(wdata1), .mem_write_enable(we1),
    .mem_read_enable(re1), .mem_read_data(rdata1)
  );

  assign rdata  = (addr < 32'd32) ? mem[addr[4:0]] : 32'd0;
  assign rdata1 = (addr1 < 32'd4) ? mem1[addr1[1:0]] : 32'd0;

  always @(posedge clk) begin
    if (load_img) begin
      for (int a = 0; a < 32; a++) mem[a] <= img[a];
    end else if (we && addr < 32'd32) begin
      mem[addr[4:0]] <= wdata;
    end
  end

  always @(posedge clk) begin
    if (load_img1) begin
      for (int a = 0; a < 4; a++) mem1[a] <= img1[a];
    end else if (we1 && addr1 < 32'd4) begin
      mem1[addr1[1:0]] <= wdata1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: textbook triple loop over the memory image, 32-bit wrapping arithmetic.
  task automatic model_c();
    logic [31:0] s;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        s = 32'd0;
        for (int x = 0; x < N; x++) s = s + img[r * N + x] * img[9 + x * N + c];
        exp_c[r * N + c] = s;
      end
    end
  endtask

  task automatic load();
    @(negedge clk);
    load_img = 1'b1;
    @(negedge clk);
    load_img = 1'b0;
  endtask

  task automatic run(input bit hold, input int window);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    first_done = -1; n_done = 0; busy_err = 0; excl_err = 0;
    for (int c = 1; c <= window; c++) begin
      @(negedge clk);
      tr_addr[c] = addr; tr_re[c] = re; tr_we[c] = we; tr_busy[c] = busy;
      if (done) begin
        n_done++;
        if (first_done < 0) first_done = c;
      end
      if (re && we) excl_err++;
      if (busy !== ((c <= LAT - 1) || (hold && c >= LAT + 2 && c <= 2 * LAT))) busy_err++;
    end
    start = 1'b0;
  endtask

  task automatic check_c(input string tag);
    for (int e = 0; e < 9; e++) check_eq($sformatf("%s_C%0d", tag, e), mem[CBASE + e], exp_c[e]);
  endtask

  task automatic check_run(input string tag);
    check_eq({tag, "_done_cycle"}, first_done, LAT);
    check_eq({tag, "_done_count"}, n_done, 1);
    check_eq({tag, "_busy_window"}, busy_err, 0);
    check_eq({tag, "_rd_wr_overlap"}, excl_err, 0);
  endtask

  initial begin
    int exp_tr [0:6];
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0; start = 1'b0; start1 = 1'b0; load_img = 1'b0; load_img1 = 1'b0;
    for (int a = 0; a < 32; a++) img[a] = 32'd0;
    for (int a = 0; a < 4; a++) img1[a] = 32'd0;
    exp_tr = '{0, 9, 1, 12, 2, 15, 18};
    repeat (2) @(negedge clk);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_addr", addr, 32'd0);
    check_eq("rst_wdata", wdata, 32'd0);
    check_eq("rst_we", we, 1'b0);
    check_eq("rst_re", re, 1'b0);
    rst_n = 1'b1;

    // Default pattern: every row of A and B is [1,2,3].
    for (int a = 0; a < 18; a++) img[a] = 32'(a % 3 + 1);
    model_c(); load(); run(1'b0, LAT + 6);
    check_run("default");
    check_c("default");
    for (int c = 1; c <= 7; c++) begin
      check_eq($sformatf("trace_addr%0d", c), tr_addr[c], exp_tr[c - 1]);
      check_eq($sformatf("trace_re%0d", c), tr_re[c], c <= 6);
      check_eq($sformatf("trace_we%0d", c), tr_we[c], c == 7);
    end

    // All-ones operands exercise wrap of product and sum.
    for (int a = 0; a < 18; a++) img[a] = 32'hFFFF_FFFF;
    for (int a = 18; a < 27; a++) img[a] = 32'd0;
    model_c(); load(); run(1'b0, LAT + 4);
    check_run("ones");
    check_c("ones");

    for (int t = 0; t < 3; t++) begin
      for (int a = 0; a < 18; a++) img[a] = (t == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      for (int a = 18; a < 27; a++) img[a] = $urandom;
      model_c(); load(); run(1'b0, LAT + 4);
      check_run($sformatf("rand%0d", t));
      check_c($sformatf("rand%0d", t));
    end

    // start held through the run and DONE: second run only after IDLE returns.
    for (int a = 0; a < 18; a++) img[a] = $urandom;
    for (int a = 18; a < 27; a++) img[a] = 32'd0;
    model_c(); load(); run(1'b1, 2 * LAT + 1);
    check_eq("hold_first_done", first_done, LAT);
    check_eq("hold_done_count", n_done, 2);
    check_eq("hold_busy_window", busy_err, 0);
    check_eq("hold_idle_gap", tr_busy[LAT + 1], 1'b0);
    check_eq("hold_restart", tr_busy[LAT + 2], 1'b1);
    check_c("hold");
    repeat (3) @(negedge clk);

    // Reset in the middle of element C[1][1].
    for (int a = 0; a < 18; a++) img[a] = $urandom;
    for (int a = 18; a < 27; a++) img[a] = 32'hDEAD_0000 + 32'(a);
    model_c(); load();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", busy, 1'b0);
    check_eq("midrst_re", re, 1'b0);
    check_eq("midrst_we", we, 1'b0);
    check_eq("midrst_addr", addr, 32'd0);
    check_eq("midrst_wdata", wdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_done = 0; busy_err = 0;
    for (int c = 0; c < LAT + 4; c++) begin
      @(negedge clk);
      if (done) n_done++;
      if (busy) busy_err++;
    end
    check_eq("midrst_no_done", n_done, 0);
    check_eq("midrst_stays_idle", busy_err, 0);
    for (int e = 0; e < 9; e++)
      check_eq($sformatf("midrst_C%0d", e), mem[CBASE + e], (e < 4) ? exp_c[e] : img[CBASE + e]);
    run(1'b0, LAT + 4);
    check_run("after_rst");
    check_c("after_rst");

    // 1x1 instance with its own base addresses.
    for (int t = 0; t < 2; t++) begin
      img1[0] = (t == 0) ? 32'd7 : $urandom;
      img1[1] = (t == 0) ? 32'd5 : $urandom;
      img1[2] = 32'hAAAA_AAAA;
      @(negedge clk); load_img1 = 1'b1;
      @(negedge clk); load_img1 = 1'b0;
      start1 = 1'b1;
      @(posedge clk); #1; start1 = 1'b0;
      first_done = -1;
      for (int c = 1; c <= LAT1 + 4; c++) begin
        @(negedge clk);
        if (done1 && first_done < 0) first_done = c;
      end
      check_eq($sformatf("n1_done_cycle%0d", t), first_done, LAT1);
      check_eq($sformatf("n1_result%0d", t), mem1[2], img1[0] * img1[1]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/matrix_multiply_sequencer.md
# matrix_multiply_sequencer

Memory-side engine that computes C = A × B for N×N word matrices held in the data memory and writes C back to it. Sits directly upstream of the data memory and drives its address/write_data/write_enable/read_enable port while busy; the datapath's memory port is muxed out using `busy`. Matrices live at fixed word addresses: A at 0, B at 9, C at 18 for N=3.

## Interface
- N, 3, matrix dimension (N ≥ 1).
- DATA_W, 32, word width.
- A_BASE, 0, word address of A[0][0], row-major.
- B_BASE, 9, word address of B[0][0], row-major.
- C_BASE, 18, word address of C[0][0], row-major.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- busy  out  1  high while the sequencer owns the memory port.
- done  out  1  one-cycle pulse after the last C write.
- mem_address  out  32  word address to data memory.
- mem_write_data  out  DATA_W  data for C writes.
- mem_write_enable  out  1  write strobe; memory captures on rising clk.
- mem_read_enable  out  1  read strobe.
- mem_read_data  in  DATA_W  combinational read data, valid in the same cycle as address/read_enable.

## Operation
- States: IDLE, RD_A, RD_B, WR, DONE.
- IDLE: all outputs 0. start=1 → clear i, j, k, acc; go RD_A.
- RD_A: address = A_BASE + i*N + k, read_enable=1; latch a_reg ← read_data; go RD_B.
- RD_B: address = B_BASE + k*N + j, read_enable=1; acc ← acc + a_reg*read_data. If k=N−1 go WR, else k++ and go RD_A.
- WR: address = C_BASE + i*N + j, write_data = acc, write_enable=1; k←0, acc←0; advance j (wrap to 0, then i++). If i=N−1 and j=N−1 go DONE, else go RD_A.
- DONE: done=1 for one cycle; go IDLE.
- Arithmetic: unsigned; product truncated to DATA_W bits; accumulation modulo 2^DATA_W; no overflow flag.
- read_enable and write_enable are never high in the same cycle.
- start is ignored outside IDLE (including DONE); no queueing.
- Reset mid-operation: return to IDLE immediately, all outputs 0, no done; C elements already written stay written.

## Timing
- Reset values: busy=0, done=0, mem_address=0, mem_write_data=0, mem_write_enable=0, mem_read_enable=0; state IDLE; i, j, k, acc, a_reg = 0.
- Outputs are decoded from registered state/counters; no combinational path from start to memory port.
- start accepted in IDLE at cycle T → first RD_A at T+1.
- Per C element: 2N+1 cycles (N×{RD_A, RD_B} + WR).
- N=3: C[0][0] written at T+7; C[i][j] written at T+7+7(i*N+j); last write (C[2][2]) at T+63.
- busy=1 for cycles T+1..T+63 inclusive (states RD_A/RD_B/WR); done=1 at T+64 with busy=0; IDLE at T+65, earliest next accept at T+65.
- Total latency start→done: N²(2N+1)+1 cycles.

## Structure
- Shared package `mm_seq_pkg`: state enum (IDLE, RD_A, RD_B, WR, DONE), default base-address constants.
- One sub-module: `mm_index_counter` — nested i/j/k counters with k-wrap, j-wrap, and last-element flags.
- Address arithmetic, MAC, and FSM in the top module.

## Test plan
- Default memory (A rows and B rows all [1,2,3]), pulse start → addresses 18..26 hold 6,12,18,6,12,18,6,12,18; done exactly once at T+64.
- Cycle trace on first element → address sequence 0,9,1,12,2,15,18 with read_enable on the first six, write_enable only on 18.
- start held high through the whole run and during DONE → exactly one run; second run begins only after IDLE is re-entered.
- A=B=all 0xFFFFFFFF → each C element = 3 (mod 2^32 wrap of 3×0x...0001).
- rst_n low at T+30 → outputs 0 immediately, no done, C[0][0..2] and C[1][0] written, C[1][1] onward unchanged; fresh start afterwards gives correct full result.
- N=1, A_BASE=0, B_BASE=1, C_BASE=2, mem[0]=7, mem[1]=5 → mem[2]=35, done at T+4.
